// File: rtl/variable_latency_credit_xbar.sv
`default_nettype none
// ============================================================================
// Module   : variable_latency_credit_xbar
// Brief    : NumIn x NumOut crossbar for variable-latency TCDM banks.
//            It has per-initiator outstanding-request credit limiting and
//            configurable bank interleaving. Request and response paths are
//            combinational and use round-robin arbitration.
//            Optional conflict counters: define VLXBAR_PERF_COUNTERS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module variable_latency_credit_xbar #(
  parameter int unsigned NumIn          = 8,
  parameter int unsigned NumOut         = 16,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned AddrMemWidth   = 12,
  parameter int unsigned ByteOffWidth   = $clog2(DataWidth - 1) - 3,
  parameter int unsigned InterleaveLog2 = 0,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IniW          = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // initiator request side
  input  logic [NumIn-1:0]        req_valid_i,
  output logic [NumIn-1:0]        req_ready_o,
  input  logic [AddrWidth-1:0]    req_tgt_addr_i [NumIn],
  input  logic [NumIn-1:0]        req_wen_i,
  input  logic [DataWidth-1:0]    req_wdata_i    [NumIn],
  input  logic [BeWidth-1:0]      req_be_i       [NumIn],
  // initiator response side
  output logic [NumIn-1:0]        resp_valid_o,
  input  logic [NumIn-1:0]        resp_ready_i,
  output logic [DataWidth-1:0]    resp_rdata_o   [NumIn],
  // target request side
  output logic [NumOut-1:0]       req_valid_o,
  input  logic [NumOut-1:0]       req_ready_i,
  output logic [IniW-1:0]         req_ini_addr_o [NumOut],
  output logic [AddrMemWidth-1:0] req_tgt_addr_o [NumOut],
  output logic [NumOut-1:0]       req_wen_o,
  output logic [DataWidth-1:0]    req_wdata_o    [NumOut],
  output logic [BeWidth-1:0]      req_be_o       [NumOut],
  // target response side
  input  logic [NumOut-1:0]       resp_valid_i,
  output logic [NumOut-1:0]       resp_ready_o,
  input  logic [IniW-1:0]         resp_ini_addr_i [NumOut],
  input  logic [DataWidth-1:0]    resp_rdata_i    [NumOut],
  // status
  input  logic                    perf_clear_i,
  output logic [31:0]             perf_conflict_o [NumOut],
  output logic                    credit_err_o
);

  localparam int unsigned BankW = $clog2(NumOut);
  localparam int unsigned CredW = $clog2(MaxOutstanding + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(MaxOutstanding);

  logic [CredW-1:0]        credit_q  [NumIn];
  logic [CredW-1:0]        credit_d  [NumIn];
  logic                    err_q, err_d;
  logic [IniW-1:0]         rr_req_q  [NumOut];
  logic [IniW-1:0]         rr_req_d  [NumOut];
  logic [BankW-1:0]        rr_resp_q [NumIn];
  logic [BankW-1:0]        rr_resp_d [NumIn];

  logic [BankW-1:0]        bank_sel  [NumIn];
  logic [AddrMemWidth-1:0] bank_addr [NumIn];
  logic [NumIn-1:0]        eligible;
  logic [NumOut-1:0]       req_any;
  logic [IniW-1:0]         req_win   [NumOut];
  logic [NumIn-1:0]        resp_any;
  logic [BankW-1:0]        resp_sel  [NumIn];
  logic [NumIn-1:0]        resp_hs;

  // Pointer advance with wrap at NumIn (NumIn need not be a power of two)
  function automatic logic [IniW-1:0] ini_inc(input logic [IniW-1:0] v);
    return (int'(v) == int'(NumIn) - 1) ? '0 : v + IniW'(1);
  endfunction

  // Address decode: bank select from the interleave field, remaining word bits form the bank address
  for (genvar i = 0; i < NumIn; i++) begin : g_decode
    logic [AddrWidth-1:0] word;
    logic                 word_unused;
    assign word        = req_tgt_addr_i[i] >> ByteOffWidth;
    assign word_unused = ^word;
    assign bank_sel[i] = word[InterleaveLog2 +: BankW];
    if (InterleaveLog2 == 0) begin : g_il_none
      assign bank_addr[i] = word[BankW +: AddrMemWidth];
    end else begin : g_il_low
      assign bank_addr[i] = {word[InterleaveLog2 + BankW +: AddrMemWidth - InterleaveLog2],
                             word[InterleaveLog2-1:0]};
    end
    // An initiator at its credit limit is invisible to every arbiter
    assign eligible[i]    = req_valid_i[i] & (credit_q[i] < CredMax);
    assign req_ready_o[i] = eligible[i] & req_any[bank_sel[i]]
                          & (req_win[bank_sel[i]] == IniW'(i)) & req_ready_i[bank_sel[i]];
    assign resp_valid_o[i] = resp_any[i];
    assign resp_rdata_o[i] = resp_rdata_i[resp_sel[i]];
    assign resp_hs[i]      = resp_any[i] & resp_ready_i[i];
  end

  // Per-target round-robin: first eligible initiator at or above the pointer, with wrap
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int t = 0; t < int'(NumOut); t++) begin
      found      = 1'b0;
      req_win[t] = '0;
      for (int k = 0; k < int'(NumIn); k++) begin
        idx = (int'(rr_req_q[t]) + k) % int'(NumIn);
        if (!found && eligible[idx] && (bank_sel[idx] == BankW'(t))) begin
          found      = 1'b1;
          req_win[t] = IniW'(idx);
        end
      end
      req_any[t]  = found;
      rr_req_d[t] = (found && req_ready_i[t]) ? ini_inc(req_win[t]) : rr_req_q[t];
    end
  end

  // Forward the winning initiator's payload to each target
  for (genvar t = 0; t < NumOut; t++) begin : g_tgt
    assign req_valid_o[t]    = req_any[t];
    assign req_ini_addr_o[t] = req_win[t];
    assign req_tgt_addr_o[t] = bank_addr[req_win[t]];
    assign req_wen_o[t]      = req_wen_i[req_win[t]];
    assign req_wdata_o[t]    = req_wdata_i[req_win[t]];
    assign req_be_o[t]       = req_be_i[req_win[t]];
  end

  // Per-initiator round-robin over targets returning data to it
  always_comb begin
    int   tdx;
    logic found;
    tdx   = 0;
    found = 1'b0;
    for (int i = 0; i < int'(NumIn); i++) begin
      found       = 1'b0;
      resp_sel[i] = '0;
      for (int k = 0; k < int'(NumOut); k++) begin
        tdx = (int'(rr_resp_q[i]) + k) % int'(NumOut);
        if (!found && resp_valid_i[tdx] && (resp_ini_addr_i[tdx] == IniW'(i))) begin
          found       = 1'b1;
          resp_sel[i] = BankW'(tdx);
        end
      end
      resp_any[i]  = found;
      rr_resp_d[i] = (found && resp_ready_i[i]) ? resp_sel[i] + BankW'(1) : rr_resp_q[i];
    end
  end

  // A target is released only when it is the one its initiator selected and that initiator is ready
  always_comb begin
    resp_ready_o = '0;
    for (int t = 0; t < int'(NumOut); t++) begin
      for (int i = 0; i < int'(NumIn); i++) begin
        if (resp_any[i] && (resp_sel[i] == BankW'(t)) && resp_ready_i[i]) begin
          resp_ready_o[t] = 1'b1;
        end
      end
    end
  end

  // Credit bookkeeping; a response with no credit outstanding is flagged and the counter stays at zero
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < int'(NumIn); i++) begin
      credit_d[i] = credit_q[i];
      if (req_ready_o[i] && !resp_hs[i]) begin
        credit_d[i] = credit_q[i] + CredW'(1);
      end else if (!req_ready_o[i] && resp_hs[i]) begin
        if (credit_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] - CredW'(1);
        end
      end
    end
  end

  // Arbitration pointers, credits and the sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < int'(NumOut); t++) rr_req_q[t] <= '0;
      for (int i = 0; i < int'(NumIn); i++) begin
        rr_resp_q[i] <= '0;
        credit_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int t = 0; t < int'(NumOut); t++) rr_req_q[t] <= rr_req_d[t];
      for (int i = 0; i < int'(NumIn); i++) begin
        rr_resp_q[i] <= rr_resp_d[i];
        credit_q[i]  <= credit_d[i];
      end
      err_q <= err_d;
    end
  end

  assign credit_err_o = err_q;

`ifdef VLXBAR_PERF_COUNTERS_EN
  logic [31:0]       perf_q [NumOut];
  logic [31:0]       perf_d [NumOut];
  logic [NumOut-1:0] conflict;

  // A conflict is two or more raw requests toward one bank, credit state ignored
  always_comb begin
    logic seen;
    logic many;
    seen = 1'b0;
    many = 1'b0;
    for (int t = 0; t < int'(NumOut); t++) begin
      seen = 1'b0;
      many = 1'b0;
      for (int i = 0; i < int'(NumIn); i++) begin
        if (req_valid_i[i] && (bank_sel[i] == BankW'(t))) begin
          if (seen) many = 1'b1;
          seen = 1'b1;
        end
      end
      conflict[t] = many;
      if (perf_clear_i) begin
        perf_d[t] = '0;
      end else if (many && (perf_q[t] != '1)) begin
        perf_d[t] = perf_q[t] + 32'd1;
      end else begin
        perf_d[t] = perf_q[t];
      end
    end
  end

  // Saturating conflict counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < int'(NumOut); t++) perf_q[t] <= '0;
    end else begin
      for (int t = 0; t < int'(NumOut); t++) perf_q[t] <= perf_d[t];
    end
  end

  for (genvar t = 0; t < NumOut; t++) begin : g_perf
    assign perf_conflict_o[t] = perf_q[t];
  end
`else
  logic perf_unused;
  assign perf_unused = perf_clear_i;
  for (genvar t = 0; t < NumOut; t++) begin : g_perf
    assign perf_conflict_o[t] = '0;
  end
`endif

endmodule
`default_nettype wire
